// File: rtl/enemy_table_ctrl.sv
// Enemy table owner: holds NUM_SLOTS enemy records in flops and schedules
// every access to them. A once-per-frame movement sweep walks the slots one
// per cycle; spawn and damage requests from game logic are served only while
// the sweep is idle. The pixel generator reads records combinationally.
//
// Record layout: [36]exist [35:24]y [23:12]x [11:5]hp [4:2]type [1:0]spd_cnt
module enemy_table_ctrl #(
    parameter int          NUM_SLOTS = 8,
    parameter int          SLOT_W    = 3,
    parameter logic [11:0] SPAWN_X   = 12'd0,
    parameter logic [11:0] BASE_X    = 12'd600
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              frame_tick,
    input  logic              spawn_req,
    input  logic [11:0]       spawn_y,
    input  logic [6:0]        spawn_hp,
    input  logic [2:0]        spawn_type,
    output logic              spawn_ack,
    output logic              spawn_ok,
    input  logic              dmg_req,
    input  logic [SLOT_W-1:0] dmg_slot,
    input  logic [6:0]        dmg_amt,
    output logic              dmg_ack,
    output logic              kill,
    output logic              base_hit,
    input  logic [SLOT_W-1:0] rd_slot,
    output logic [36:0]       rd_data,
    output logic [SLOT_W:0]   alive_cnt,
    output logic              busy,
    output logic              tick_overrun
);

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [36:0]       tbl_q [NUM_SLOTS];
    logic [SLOT_W-1:0] sweep_idx;
    logic              pending;

    logic              in_idle;
    logic              in_sweep;
    logic              last_slot;
    logic              start_sweep;
    logic              serve_dmg;
    logic              serve_spawn;

    logic              free_found;
    logic [SLOT_W-1:0] free_idx;
    logic [SLOT_W:0]   live_cnt;

    logic [36:0]       sw_rec;
    logic [12:0]       sw_x_sum;
    logic              sw_reach;
    logic [36:0]       sw_new;

    logic [36:0]       dm_rec;
    logic [6:0]        dm_hp;
    logic              dm_kill;
    logic [6:0]        sp_hp;

    // Hit points never go below zero; damage larger than hp simply empties it.
    function automatic logic [6:0] sat_sub_hp(input logic [6:0] hp, input logic [6:0] amt);
        return (hp > amt) ? (hp - amt) : 7'd0;
    endfunction

    assign in_idle   = (state == ST_IDLE);
    assign in_sweep  = (state == ST_SWEEP);
    assign last_slot = (sweep_idx == SLOT_W'(NUM_SLOTS - 1));

    // Priority in IDLE: sweep start, then damage, then spawn. A request whose
    // ack is currently high is the same transaction still being held, so it
    // is not served a second time.
    assign start_sweep = in_idle && (frame_tick || pending);
    assign serve_dmg   = in_idle && !start_sweep && dmg_req && !dmg_ack;
    assign serve_spawn = in_idle && !start_sweep && !serve_dmg && spawn_req && !spawn_ack;

    assign rd_data = tbl_q[rd_slot];

    // Lowest-index empty slot for a spawn, and the live-slot population count.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        live_cnt   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!tbl_q[i][36]) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            live_cnt = live_cnt + {{SLOT_W{1'b0}}, tbl_q[i][36]};
        end
    end

    // Movement step for the slot under the sweep pointer; x is widened by one
    // bit so a large BASE_X near the top of the range cannot be skipped by wrap.
    always_comb begin
        sw_rec   = tbl_q[sweep_idx];
        sw_x_sum = {1'b0, sw_rec[23:12]};
        if (sw_rec[1:0] == 2'd3) begin
            sw_x_sum = sw_x_sum + (sw_rec[4] ? 13'd2 : 13'd1);
        end
        sw_reach = sw_rec[36] && (sw_x_sum >= {1'b0, BASE_X});
        sw_new   = {sw_rec[36:24], sw_x_sum[11:0], sw_rec[11:2], sw_rec[1:0] + 2'd1};
    end

    // Damage result for the addressed slot and the initial hp of a new enemy.
    always_comb begin
        dm_rec  = tbl_q[dmg_slot];
        dm_hp   = sat_sub_hp(dm_rec[11:5], dmg_amt);
        dm_kill = dm_rec[36] && (dm_hp == 7'd0);
        sp_hp   = (spawn_hp == 7'd0) ? 7'd1 : spawn_hp;
    end

    // State register; clear behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a sweep covers every slot once, then returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_sweep) state_nxt = ST_SWEEP;
            ST_SWEEP: if (last_slot)   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = in_sweep;
    end

    // Table, handshake outputs, tick bookkeeping and population register.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                tbl_q[i] <= '0;
            end
            sweep_idx    <= '0;
            pending      <= 1'b0;
            tick_overrun <= 1'b0;
            spawn_ack    <= 1'b0;
            spawn_ok     <= 1'b0;
            dmg_ack      <= 1'b0;
            kill         <= 1'b0;
            base_hit     <= 1'b0;
            alive_cnt    <= '0;
        end else begin
            spawn_ack <= serve_spawn;
            spawn_ok  <= serve_spawn && free_found;
            dmg_ack   <= serve_dmg;
            kill      <= serve_dmg && dm_kill;
            base_hit  <= in_sweep && sw_reach;
            alive_cnt <= live_cnt;

            if (in_sweep) begin
                sweep_idx <= last_slot ? '0 : sweep_idx + 1'b1;
                if (frame_tick) begin
                    if (pending) begin
                        tick_overrun <= 1'b1;
                    end else begin
                        pending <= 1'b1;
                    end
                end
                if (sw_rec[36]) begin
                    tbl_q[sweep_idx] <= sw_reach ? '0 : sw_new;
                end
            end else if (start_sweep) begin
                // A fresh tick arriving while a deferred one starts stays queued.
                pending <= pending && frame_tick;
            end

            if (serve_dmg && dm_rec[36]) begin
                tbl_q[dmg_slot] <= dm_kill ? '0 : {dm_rec[36:12], dm_hp, dm_rec[4:0]};
            end

            if (serve_spawn && free_found) begin
                tbl_q[free_idx] <= {1'b1, spawn_y, SPAWN_X, sp_hp, spawn_type, 2'b00};
            end
        end
    end

endmodule

// File: tb/tb_enemy_table_ctrl.sv
// Self-checking bench for enemy_table_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// record-level reference model of the enemy table.
module tb_enemy_table_ctrl;

    localparam int          NUM_SLOTS = 8;
    localparam int          SLOT_W    = 3;
    localparam logic [11:0] SPAWN_X   = 12'd0;
    localparam int          BASE_X    = 2;

    logic              clk;
    logic              rst;
    logic              clear;
    logic              frame_tick;
    logic              spawn_req;
    logic [11:0]       spawn_y;
    logic [6:0]        spawn_hp;
    logic [2:0]        spawn_type;
    logic              spawn_ack;
    logic              spawn_ok;
    logic              dmg_req;
    logic [SLOT_W-1:0] dmg_slot;
    logic [6:0]        dmg_amt;
    logic              dmg_ack;
    logic              kill;
    logic              base_hit;
    logic [SLOT_W-1:0] rd_slot;
    logic [36:0]       rd_data;
    logic [SLOT_W:0]   alive_cnt;
    logic              busy;
    logic              tick_overrun;

    enemy_table_ctrl #(
        .NUM_SLOTS(NUM_SLOTS),
        .SLOT_W   (SLOT_W),
        .SPAWN_X  (SPAWN_X),
        .BASE_X   (12'(BASE_X))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .frame_tick  (frame_tick),
        .spawn_req   (spawn_req),
        .spawn_y     (spawn_y),
        .spawn_hp    (spawn_hp),
        .spawn_type  (spawn_type),
        .spawn_ack   (spawn_ack),
        .spawn_ok    (spawn_ok),
        .dmg_req     (dmg_req),
        .dmg_slot    (dmg_slot),
        .dmg_amt     (dmg_amt),
        .dmg_ack     (dmg_ack),
        .kill        (kill),
        .base_hit    (base_hit),
        .rd_slot     (rd_slot),
        .rd_data     (rd_data),
        .alive_cnt   (alive_cnt),
        .busy        (busy),
        .tick_overrun(tick_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        bit ex;
        int y;
        int x;
        int hp;
        int typ;
        int spd;
    } rec_t;

    rec_t mt [NUM_SLOTS];
    int   m_pos   = -1;   // slot the sweep visits at the next edge, -1 when idle
    bit   m_pend  = 0;
    bit   m_ovr   = 0;
    bit   m_sack  = 0;
    bit   m_sok   = 0;
    bit   m_dack  = 0;
    bit   m_kill  = 0;
    bit   m_bhit  = 0;
    int   m_alive = 0;

    function automatic logic [36:0] pack(input rec_t r);
        return {1'(r.ex), 12'(r.y), 12'(r.x), 7'(r.hp), 3'(r.typ), 2'(r.spd)};
    endfunction

    // Advance the model across one clock edge using the inputs now applied.
    function automatic void model_step();
        int live = 0;
        int h;
        bit sack = 0, sok = 0, dack = 0, kl = 0, bh = 0;
        for (int i = 0; i < NUM_SLOTS; i++) if (mt[i].ex) live++;
        if (rst || clear) begin
            for (int i = 0; i < NUM_SLOTS; i++) mt[i] = '0;
            m_pos = -1; m_pend = 0; m_ovr = 0; live = 0;
        end else if (m_pos >= 0) begin
            if (mt[m_pos].ex) begin
                if (mt[m_pos].spd == 3) mt[m_pos].x += (mt[m_pos].typ >= 4) ? 2 : 1;
                mt[m_pos].spd = (mt[m_pos].spd + 1) % 4;
                if (mt[m_pos].x >= BASE_X) begin
                    mt[m_pos] = '0;
                    bh = 1;
                end
            end
            if (frame_tick) begin
                if (m_pend) m_ovr = 1;
                else        m_pend = 1;
            end
            m_pos = (m_pos == NUM_SLOTS - 1) ? -1 : m_pos + 1;
        end else if (frame_tick || m_pend) begin
            m_pend = frame_tick && m_pend;
            m_pos  = 0;
        end else if (dmg_req && !m_dack) begin
            dack = 1;
            if (mt[dmg_slot].ex) begin
                h = mt[dmg_slot].hp - int'(dmg_amt);
                if (h <= 0) begin
                    mt[dmg_slot] = '0;
                    kl = 1;
                end else begin
                    mt[dmg_slot].hp = h;
                end
            end
        end else if (spawn_req && !m_sack) begin
            sack = 1;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (!sok && !mt[i].ex) begin
                    mt[i].ex  = 1;
                    mt[i].y   = int'(spawn_y);
                    mt[i].x   = int'(SPAWN_X);
                    mt[i].hp  = (spawn_hp == 0) ? 1 : int'(spawn_hp);
                    mt[i].typ = int'(spawn_type);
                    mt[i].spd = 0;
                    sok = 1;
                end
            end
        end
        m_sack = sack; m_sok = sok; m_dack = dack; m_kill = kl; m_bhit = bh;
        m_alive = live;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("spawn_ack", spawn_ack, m_sack);
        if (m_sack) chk("spawn_ok", spawn_ok, m_sok);
        chk("dmg_ack", dmg_ack, m_dack);
        chk("kill", kill, m_kill);
        chk("base_hit", base_hit, m_bhit);
        chk("busy", busy, (m_pos >= 0));
        chk("alive_cnt", alive_cnt, m_alive);
        chk("tick_overrun", tick_overrun, m_ovr);
        chk("rd_data", rd_data, pack(mt[rd_slot]));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic peek(input int slot, input logic [36:0] exp, input string name);
        rd_slot = SLOT_W'(slot);
        #1;
        chk(name, rd_data, exp);
    endtask

    task automatic spawn_one(input int y, input int hp, input int typ, input bit exp_ok, input string name);
        bit got = 0;
        spawn_y = 12'(y); spawn_hp = 7'(hp); spawn_type = 3'(typ); spawn_req = 1;
        for (int n = 0; n < 64 && !got; n++) begin
            step();
            got = m_sack;
        end
        chk({name, "_ack"}, spawn_ack, 1);
        chk({name, "_ok"}, spawn_ok, exp_ok);
        step();
        spawn_req = 0;
    endtask

    task automatic dmg_one(input int slot, input int amt, input bit exp_kill, input string name);
        bit got = 0;
        dmg_slot = SLOT_W'(slot); dmg_amt = 7'(amt); dmg_req = 1;
        for (int n = 0; n < 64 && !got; n++) begin
            step();
            got = m_dack;
        end
        chk({name, "_ack"}, dmg_ack, 1);
        chk({name, "_kill"}, kill, exp_kill);
        step();
        dmg_req = 0;
    endtask

    task automatic frame(output int bh);
        int n = 0;
        bh = 0;
        frame_tick = 1;
        step();
        frame_tick = 0;
        if (base_hit) bh++;
        while (m_pos >= 0 && n < 40) begin
            step();
            if (base_hit) bh++;
            n++;
        end
        chk("frame_done_busy", busy, 0);
    endtask

    task automatic pulse_clear();
        clear = 1;
        step();
        clear = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  bh, dn, sn, lb, busy_tot, rises;
        bit  prev_busy;
        bit  sp_rel, dm_rel;

        rst = 1; clear = 0; frame_tick = 0;
        spawn_req = 0; spawn_y = 0; spawn_hp = 0; spawn_type = 0;
        dmg_req = 0; dmg_slot = 0; dmg_amt = 0; rd_slot = 0;
        for (int i = 0; i < NUM_SLOTS; i++) mt[i] = '0;

        // Reset state
        step(); step();
        rst = 0;
        chk("rst_spawn_ack", spawn_ack, 0);
        chk("rst_dmg_ack", dmg_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alive", alive_cnt, 0);
        chk("rst_overrun", tick_overrun, 0);
        chk("rst_rd_data", rd_data, 0);

        // Three spawns fill slots 0..2
        for (int i = 0; i < 3; i++) spawn_one(100, 20, 0, 1, "t1_spawn");
        peek(0, {1'b1, 12'd100, 12'd0, 7'd20, 3'd0, 2'd0}, "t1_slot0");
        peek(2, {1'b1, 12'd100, 12'd0, 7'd20, 3'd0, 2'd0}, "t1_slot2");
        chk("t1_alive", alive_cnt, 3);

        // Fill to eight, ninth spawn reports full
        for (int i = 3; i < 8; i++) spawn_one(200 + i, 1 + i, i, 1, "t2_fill");
        peek(7, {1'b1, 12'd207, 12'd0, 7'd8, 3'd7, 2'd0}, "t2_slot7");
        spawn_one(300, 9, 1, 0, "t2_full");
        chk("t2_alive", alive_cnt, 8);

        // Damage: partial, then lethal
        dmg_one(2, 5, 0, "t3_dmg5");
        peek(2, {1'b1, 12'd100, 12'd0, 7'd15, 3'd0, 2'd0}, "t3_hp15");
        dmg_one(2, 30, 1, "t3_dmg30");
        peek(2, 37'd0, "t3_cleared");
        chk("t3_alive", alive_cnt, 7);

        // Movement and base reach
        pulse_clear();
        chk("t4_clear_alive", alive_cnt, 0);
        spawn_one(50, 10, 4, 1, "t4_fast");
        spawn_one(60, 10, 0, 1, "t4_slow");
        for (int i = 0; i < 3; i++) frame(bh);
        peek(0, {1'b1, 12'd50, 12'd0, 7'd10, 3'd4, 2'd3}, "t4_fast_f3");
        peek(1, {1'b1, 12'd60, 12'd0, 7'd10, 3'd0, 2'd3}, "t4_slow_f3");
        frame(bh);
        chk("t4_base_hit_pulses", bh, 1);
        peek(0, 37'd0, "t4_fast_gone");
        peek(1, {1'b1, 12'd60, 12'd1, 7'd10, 3'd0, 2'd0}, "t4_slow_f4");
        step();
        chk("t4_alive", alive_cnt, 1);

        // Arbitration: damage before spawn; requests held across a sweep
        pulse_clear();
        dmg_slot = 3; dmg_amt = 1; dmg_req = 1;
        spawn_y = 7; spawn_hp = 0; spawn_type = 1; spawn_req = 1;
        dn = -1; sn = -1;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (dmg_ack && dn < 0) dn = n;
            if (spawn_ack && sn < 0) sn = n;
            if (dn >= 0 && n == dn + 1) dmg_req = 0;
            if (sn >= 0 && n == sn + 1) spawn_req = 0;
        end
        chk("t5_dmg_first", dn, 1);
        chk("t5_spawn_next", sn, 2);
        peek(0, {1'b1, 12'd7, 12'd0, 7'd1, 3'd1, 2'd0}, "t5_hp0_as_1");

        frame_tick = 1;
        spawn_y = 9; spawn_hp = 3; spawn_type = 2; spawn_req = 1;
        sn = -1; lb = -1;
        for (int n = 1; n <= 30; n++) begin
            step();
            frame_tick = 0;
            if (busy) lb = n;
            if (spawn_ack && sn < 0) sn = n;
            if (sn >= 0 && n == sn + 1) spawn_req = 0;
        end
        chk("t5_busy_last", lb, NUM_SLOTS);
        chk("t5_spawn_after_sweep", sn, NUM_SLOTS + 2);

        // Tick overrun and deferred sweep
        pulse_clear();
        busy_tot = 0; rises = 0; prev_busy = 0;
        for (int n = 1; n <= 30; n++) begin
            frame_tick = (n == 1 || n == 4 || n == 6);
            step();
            if (busy) busy_tot++;
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        frame_tick = 0;
        chk("t6_busy_cycles", busy_tot, 2 * NUM_SLOTS);
        chk("t6_sweeps", rises, 2);
        chk("t6_overrun", tick_overrun, 1);
        pulse_clear();
        chk("t6_clear_overrun", tick_overrun, 0);
        chk("t6_clear_busy", busy, 0);

        // Reset in the middle of a sweep that would hit the base
        spawn_one(70, 5, 4, 1, "t7_spawn");
        for (int i = 0; i < 3; i++) frame(bh);
        frame_tick = 1;
        step();
        frame_tick = 0;
        rst = 1;
        step();
        rst = 0;
        chk("t7_no_base_hit", base_hit, 0);
        chk("t7_busy", busy, 0);
        peek(0, 37'd0, "t7_slot0");
        step();
        chk("t7_no_base_hit_late", base_hit, 0);
        chk("t7_alive", alive_cnt, 0);

        // Randomized traffic
        sp_rel = 0; dm_rel = 0;
        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom_range(0, 999) == 0);
            clear      = ($urandom_range(0, 299) == 0);
            frame_tick = ($urandom_range(0, 13) == 0);
            rd_slot    = SLOT_W'($urandom_range(0, NUM_SLOTS - 1));
            if (spawn_req) begin
                if (sp_rel) begin
                    spawn_req = 0; sp_rel = 0;
                end else if (m_sack) begin
                    sp_rel = 1;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                spawn_req  = 1;
                spawn_y    = 12'($urandom);
                spawn_hp   = 7'($urandom_range(0, 30));
                spawn_type = 3'($urandom);
            end
            if (dmg_req) begin
                if (dm_rel) begin
                    dmg_req = 0; dm_rel = 0;
                end else if (m_dack) begin
                    dm_rel = 1;
                end
            end else if ($urandom_range(0, 4) == 0) begin
                dmg_req  = 1;
                dmg_slot = SLOT_W'($urandom_range(0, NUM_SLOTS - 1));
                dmg_amt  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 8));
            end
            step();
        end

        rst = 0; clear = 0; frame_tick = 0; spawn_req = 0; dmg_req = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
